// File: rtl/pueo_time_capture_pkg.sv
// Shared register map, field positions and bus FSM encoding for the
// multi-channel event timestamp bank.
package pueo_time_capture_pkg;

    localparam logic [7:0] CTRL_OFF      = 8'h00;
    localparam logic [7:0] STATUS_OFF    = 8'h04;
    localparam logic [7:0] SNAP_OFF      = 8'h08;
    localparam logic [7:0] SNAP_BASE_OFF = 8'h10;
    localparam int         SNAP_STRIDE   = 8;

    localparam int CTRL_HOLDOFF_LSB  = 16;
    localparam int STATUS_MISSED_LSB = 16;
    localparam int SNAP_CNT_LSB      = 16;
    localparam int SNAP_CH_WIDTH     = 4;
    localparam int COUNT_WIDTH       = 16;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/pueo_time_capture_chan.sv
// One event channel: rising-edge detect, holdoff, DEPTH-deep history of
// {time, second}, 16-bit event count and new/missed flags.
module pueo_time_capture_chan
    import pueo_time_capture_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int CNT_WIDTH     = 32,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  logic                                event_i,
    input  logic [HOLDOFF_WIDTH-1:0]            holdoff_i,
    input  logic [CNT_WIDTH-1:0]                time_i,
    input  logic [31:0]                         sec_i,
    input  logic                                snap_clr_i,
    input  logic                                clr_new_i,
    input  logic                                clr_missed_i,
    output logic [DEPTH-1:0][CNT_WIDTH-1:0]     hist_time_o,
    output logic [DEPTH-1:0][31:0]              hist_sec_o,
    output logic [COUNT_WIDTH-1:0]              count_o,
    output logic                                new_o,
    output logic                                missed_o
);

    logic                            event_q;
    logic [DEPTH-1:0][CNT_WIDTH-1:0] hist_time_q, hist_time_d;
    logic [DEPTH-1:0][31:0]          hist_sec_q, hist_sec_d;
    logic [COUNT_WIDTH-1:0]          count_q, count_d;
    logic [HOLDOFF_WIDTH-1:0]        holdoff_q, holdoff_d;
    logic                            new_q, new_d;
    logic                            missed_q, missed_d;
    logic                            rise;
    logic                            accept;

    always_comb begin
        rise        = event_i & ~event_q & en_i;
        accept      = rise & (holdoff_q == '0);
        hist_time_d = hist_time_q;
        hist_sec_d  = hist_sec_q;
        count_d     = count_q;
        holdoff_d   = holdoff_q;
        new_d       = new_q;
        missed_d    = missed_q;

        if (accept) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                hist_time_d[k] = hist_time_q[k-1];
                hist_sec_d[k]  = hist_sec_q[k-1];
            end
            hist_time_d[0] = time_i;
            hist_sec_d[0]  = sec_i;
            count_d        = count_q + COUNT_WIDTH'(1);
            holdoff_d      = holdoff_i;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HOLDOFF_WIDTH'(1);
        end

        if (snap_clr_i | clr_new_i) new_d = 1'b0;
        if (snap_clr_i | clr_missed_i) missed_d = 1'b0;
        // A capture always wins over a clear; an overrun only counts against
        // a new flag the host has not consumed through a snapshot this cycle.
        if (accept) begin
            new_d = 1'b1;
            if (new_q & ~snap_clr_i) missed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_q     <= 1'b0;
            hist_time_q <= '0;
            hist_sec_q  <= '0;
            count_q     <= '0;
            holdoff_q   <= '0;
            new_q       <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            event_q     <= event_i;
            hist_time_q <= hist_time_d;
            hist_sec_q  <= hist_sec_d;
            count_q     <= count_d;
            holdoff_q   <= holdoff_d;
            new_q       <= new_d;
            missed_q    <= missed_d;
        end
    end

    assign hist_time_o = hist_time_q;
    assign hist_sec_o  = hist_sec_q;
    assign count_o     = count_q;
    assign new_o       = new_q;
    assign missed_o    = missed_q;

endmodule

// File: rtl/pueo_time_capture_bank.sv
// Multi-channel event timestamp bank with a Wishbone target, CTRL/STATUS
// registers and an atomic per-channel snapshot for coherent multi-word reads.
module pueo_time_capture_bank
    import pueo_time_capture_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DEPTH         = 2,
    parameter int CNT_WIDTH     = 32,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [12:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    input  logic [CNT_WIDTH-1:0] time_i,
    input  logic [31:0]          sec_i,
    input  logic [NUM_CH-1:0]    event_i,
    output logic [NUM_CH-1:0]    new_o
);

    // Handshake: a request is cyc&stb sampled in IDLE; the access (write and
    // read-data load) happens on that edge and ack is asserted for exactly the
    // following cycle, gated by cyc so an abandoned cycle never sees an ack.
    bus_state_e                                   state_q, state_d;
    logic [NUM_CH-1:0]                            en_q, en_d;
    logic [HOLDOFF_WIDTH-1:0]                     holdoff_q, holdoff_d;
    logic [31:0]                                  dat_q, dat_d;
    logic [SNAP_CH_WIDTH-1:0]                     snap_ch_q, snap_ch_d;
    logic [COUNT_WIDTH-1:0]                       snap_cnt_q, snap_cnt_d;
    logic [DEPTH-1:0][CNT_WIDTH-1:0]              snap_time_q, snap_time_d;
    logic [DEPTH-1:0][31:0]                       snap_sec_q, snap_sec_d;

    logic [NUM_CH-1:0][DEPTH-1:0][CNT_WIDTH-1:0]  ch_time;
    logic [NUM_CH-1:0][DEPTH-1:0][31:0]           ch_sec;
    logic [NUM_CH-1:0][COUNT_WIDTH-1:0]           ch_count;
    logic [NUM_CH-1:0]                            ch_new;
    logic [NUM_CH-1:0]                            ch_missed;
    logic [NUM_CH-1:0]                            snap_pulse;
    logic [NUM_CH-1:0]                            clr_new;
    logic [NUM_CH-1:0]                            clr_missed;

    logic                     bus_start;
    logic                     wr;
    logic                     snap_wr;
    logic [5:0]               word;
    logic [5:0]               rel;
    logic [SNAP_CH_WIDTH-1:0] snap_ch;
    logic [31:0]              byte_mask;
    logic [31:0]              ctrl_rd;
    logic [31:0]              status_rd;
    logic [31:0]              ctrl_wr;
    logic [31:0]              w1c;
    logic [31:0]              rd_data;
    logic                     unused_ok;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        pueo_time_capture_chan #(
            .DEPTH        (DEPTH),
            .CNT_WIDTH    (CNT_WIDTH),
            .HOLDOFF_WIDTH(HOLDOFF_WIDTH)
        ) u_chan (
            .clk_i       (wb_clk_i),
            .rst_ni      (wb_rst_n_i),
            .en_i        (en_q[c]),
            .event_i     (event_i[c]),
            .holdoff_i   (holdoff_q),
            .time_i      (time_i),
            .sec_i       (sec_i),
            .snap_clr_i  (snap_pulse[c]),
            .clr_new_i   (clr_new[c]),
            .clr_missed_i(clr_missed[c]),
            .hist_time_o (ch_time[c]),
            .hist_sec_o  (ch_sec[c]),
            .count_o     (ch_count[c]),
            .new_o       (ch_new[c]),
            .missed_o    (ch_missed[c])
        );
    end

    always_comb begin
        state_d = BUS_IDLE;
        case (state_q)
            BUS_IDLE: state_d = (wb_cyc_i & wb_stb_i) ? BUS_ACK : BUS_IDLE;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        bus_start = (state_q == BUS_IDLE) & wb_cyc_i & wb_stb_i;
        wr        = bus_start & wb_we_i;
        word      = wb_adr_i[7:2];
        rel       = word - SNAP_BASE_OFF[7:2];
        snap_ch   = wb_dat_i[SNAP_CH_WIDTH-1:0];

        for (int i = 0; i < 4; i++) byte_mask[8*i +: 8] = {8{wb_sel_i[i]}};

        ctrl_rd = '0;
        ctrl_rd[NUM_CH-1:0] = en_q;
        ctrl_rd[CTRL_HOLDOFF_LSB +: HOLDOFF_WIDTH] = holdoff_q;
        status_rd = '0;
        status_rd[NUM_CH-1:0] = ch_new;
        status_rd[STATUS_MISSED_LSB +: NUM_CH] = ch_missed;

        ctrl_wr = (ctrl_rd & ~byte_mask) | (wb_dat_i & byte_mask);
        w1c     = wb_dat_i & byte_mask;

        en_d      = en_q;
        holdoff_d = holdoff_q;
        if (wr && word == CTRL_OFF[7:2]) begin
            en_d      = ctrl_wr[NUM_CH-1:0];
            holdoff_d = ctrl_wr[CTRL_HOLDOFF_LSB +: HOLDOFF_WIDTH];
        end

        clr_new    = '0;
        clr_missed = '0;
        if (wr && word == STATUS_OFF[7:2]) begin
            clr_new    = w1c[NUM_CH-1:0];
            clr_missed = w1c[STATUS_MISSED_LSB +: NUM_CH];
        end

        snap_wr = wr && (word == SNAP_OFF[7:2]) && wb_sel_i[0]
                  && ({{(32-SNAP_CH_WIDTH){1'b0}}, snap_ch} < 32'(NUM_CH));
        snap_pulse  = '0;
        snap_ch_d   = snap_ch_q;
        snap_cnt_d  = snap_cnt_q;
        snap_time_d = snap_time_q;
        snap_sec_d  = snap_sec_q;
        // The snapshot samples channel registers before this edge's capture,
        // so a coincident event lands in history and is seen on the next SNAP.
        for (int c = 0; c < NUM_CH; c++) begin
            if (snap_wr && snap_ch == SNAP_CH_WIDTH'(c)) begin
                snap_pulse[c] = 1'b1;
                snap_ch_d     = snap_ch;
                snap_cnt_d    = ch_count[c];
                snap_time_d   = ch_time[c];
                snap_sec_d    = ch_sec[c];
            end
        end

        rd_data = '0;
        if (word == CTRL_OFF[7:2]) begin
            rd_data = ctrl_rd;
        end else if (word == STATUS_OFF[7:2]) begin
            rd_data = status_rd;
        end else if (word == SNAP_OFF[7:2]) begin
            rd_data[SNAP_CNT_LSB +: COUNT_WIDTH] = snap_cnt_q;
            rd_data[SNAP_CH_WIDTH-1:0]           = snap_ch_q;
        end else if (word >= SNAP_BASE_OFF[7:2]) begin
            // Entries are two words apart: even word is time, odd is second.
            for (int k = 0; k < DEPTH; k++) begin
                if (rel[5:1] == 5'(k)) begin
                    rd_data = rel[0] ? snap_sec_q[k] : 32'(snap_time_q[k]);
                end
            end
        end

        dat_d = bus_start ? rd_data : dat_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= BUS_IDLE;
            en_q        <= '0;
            holdoff_q   <= '0;
            dat_q       <= '0;
            snap_ch_q   <= '0;
            snap_cnt_q  <= '0;
            snap_time_q <= '0;
            snap_sec_q  <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            holdoff_q   <= holdoff_d;
            dat_q       <= dat_d;
            snap_ch_q   <= snap_ch_d;
            snap_cnt_q  <= snap_cnt_d;
            snap_time_q <= snap_time_d;
            snap_sec_q  <= snap_sec_d;
        end
    end

    assign wb_ack_o  = (state_q == BUS_ACK) & wb_cyc_i;
    assign wb_dat_o  = dat_q;
    assign wb_err_o  = 1'b0;
    assign wb_rty_o  = 1'b0;
    assign new_o     = ch_new;
    assign unused_ok = ^{wb_adr_i[12:8], wb_adr_i[1:0], ctrl_wr, w1c, wb_dat_i};

endmodule
